// File: rtl/wm_cycle_controller.sv
// Wash-cycle sequencer: state bus for the cycle timer, actuator enables, interlock, pause, cancel and watchdog.
// Latency: an input sampled at edge N sets state and all outputs visible in cycle N+1. All outputs are registered.
// Backpressure: pause freezes the state and the dwell counter in FILL..SPIN. Actuators turn off; the door lock stays on.
module wm_cycle_controller #(
  parameter int LOCK_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int WD_W           = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       pause,
  input  logic       cold_wash,
  input  logic       door_closed,
  input  logic       clear_fault,
  input  logic       sig_Full,
  input  logic       sig_Temperature,
  input  logic       sig_Completed,
  output logic [2:0] state,
  output logic       door_lock,
  output logic       water_valve,
  output logic       heater,
  output logic       motor,
  output logic       drain,
  output logic       done,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_DOOR_LOCK = 3'd1,
    S_FILL      = 3'd2,
    S_HEAT      = 3'd3,
    S_WASH      = 3'd4,
    S_RINSE     = 3'd5,
    S_SPIN      = 3'd6,
    S_FAULT     = 3'd7
  } st_t;

  localparam logic [WD_W-1:0] TO_VAL   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] LOCK_END = WD_W'(LOCK_CYCLES - 1);

  st_t             cur, nxt, norm;
  logic [WD_W-1:0] dwell, dwell_nxt;
  logic            active, running, cancellable, qual, act_on;
  logic            lock_nxt, valve_nxt, heater_nxt, motor_nxt, drain_nxt, done_nxt, fault_nxt;

  assign state = cur;

  // Next state by priority: door interlock, cancel, pause hold, normal exit, and then watchdog.
  always_comb begin
    nxt         = cur;
    norm        = cur;
    active      = (cur != S_IDLE) && (cur != S_FAULT);
    running     = active && (cur != S_DOOR_LOCK);
    cancellable = active && (cur != S_SPIN);
    // The entry cycle is blanked so that a timer flag left high by the previous phase cannot skip a phase.
    qual        = (dwell != '0);
    case (cur)
      S_IDLE:      if (start && door_closed) norm = S_DOOR_LOCK;
      S_DOOR_LOCK: if (dwell == LOCK_END) norm = S_FILL;
      S_FILL:      if (qual && sig_Full) norm = cold_wash ? S_WASH : S_HEAT;
      S_HEAT:      if (qual && sig_Temperature) norm = S_WASH;
      S_WASH:      if (qual && sig_Completed) norm = S_RINSE;
      S_RINSE:     if (qual && sig_Completed) norm = S_SPIN;
      S_SPIN:      if (qual && sig_Completed) norm = S_IDLE;
      S_FAULT:     if (clear_fault) norm = S_IDLE;
      default:     norm = S_IDLE;
    endcase
    if (active && !door_closed)                        nxt = S_FAULT;
    else if (cancellable && cancel)                    nxt = S_SPIN;
    else if (running && pause)                         nxt = cur;
    // The watchdog fires only when no exit is taken this cycle, so an exit flag wins over the timeout.
    else if (running && norm == cur && dwell == TO_VAL) nxt = S_FAULT;
    else                                               nxt = norm;
  end

  // Dwell counter and Moore output decode, both computed from the state being entered.
  always_comb begin
    dwell_nxt = dwell;
    if (nxt != cur)                    dwell_nxt = '0;
    else if (!pause && dwell < TO_VAL) dwell_nxt = dwell + 1'b1;
    lock_nxt   = (nxt != S_IDLE) && (nxt != S_FAULT);
    act_on     = !(pause && lock_nxt && nxt != S_DOOR_LOCK);
    valve_nxt  = act_on && (nxt == S_FILL || nxt == S_RINSE);
    heater_nxt = act_on && (nxt == S_HEAT);
    motor_nxt  = act_on && (nxt == S_WASH || nxt == S_RINSE || nxt == S_SPIN);
    drain_nxt  = act_on && (nxt == S_SPIN);
    done_nxt   = (cur == S_SPIN) && (nxt == S_IDLE);
    fault_nxt  = (nxt == S_FAULT);
  end

  // State, dwell and output registers. Reset returns to IDLE with everything off and no done pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      cur         <= S_IDLE;
      dwell       <= '0;
      door_lock   <= 1'b0;
      water_valve <= 1'b0;
      heater      <= 1'b0;
      motor       <= 1'b0;
      drain       <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
    end else begin
      cur         <= nxt;
      dwell       <= dwell_nxt;
      door_lock   <= lock_nxt;
      water_valve <= valve_nxt;
      heater      <= heater_nxt;
      motor       <= motor_nxt;
      drain       <= drain_nxt;
      done        <= done_nxt;
      fault       <= fault_nxt;
    end
  end

endmodule
